// File: rtl/dram_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_slot_arbiter_pkg
// Purpose  : Shared MCU RAM constants: slot owner encodings and refresh rate.
// Revision : 1.0 - initial release
// ============================================================================
package dram_slot_arbiter_pkg;

    localparam int c_ref_div_default = 32;

    typedef enum logic [2:0] {
        SRC_IDLE = 3'd0,
        SRC_CPU  = 3'd1,
        SRC_VID  = 3'd2,
        SRC_SND  = 3'd3,
        SRC_DMA  = 3'd4,
        SRC_REF  = 3'd5
    } src_t;

    typedef enum logic {
        PH_DMA = 1'b0,
        PH_CPU = 1'b1
    } phase_t;

    // Fixed-priority owner of a DMA slot; refresh always wins.
    function automatic src_t dma_grant(input logic pend, input logic vid,
                                       input logic snd, input logic dma);
        if (pend)     return SRC_REF;
        else if (vid) return SRC_VID;
        else if (snd) return SRC_SND;
        else if (dma) return SRC_DMA;
        else          return SRC_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_slot_arbiter_if
// Purpose  : Slot strobe, RAM requesters and slot owner / acknowledge bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_slot_arbiter_if;

    logic       slot_en;
    logic       cpu_req;
    logic       vid_req;
    logic       snd_req;
    logic       dma_req;
    logic [2:0] src;
    logic       ram_cyc;
    logic       refb;
    logic       vid_ack;
    logic       snd_ack;
    logic       dma_ack;
    logic       cpu_dtack_n;

    modport master (
        output slot_en, cpu_req, vid_req, snd_req, dma_req,
        input  src, ram_cyc, refb, vid_ack, snd_ack, dma_ack, cpu_dtack_n
    );

    modport slave (
        input  slot_en, cpu_req, vid_req, snd_req, dma_req,
        output src, ram_cyc, refb, vid_ack, snd_ack, dma_ack, cpu_dtack_n
    );

endinterface
`default_nettype wire

// File: rtl/dram_slot_arbiter_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : refresh_timer
// Purpose  : Counts DMA slots and raises a sticky refresh request every REF_DIV.
// Revision : 1.0 - initial release
// ============================================================================
module refresh_timer #(
    parameter int REF_DIV = 32
) (
    input  wire  clk32,
    input  wire  porb,
    input  wire  tick,
    input  wire  clr,
    output logic pend
);

    localparam int c_cnt_w = $clog2(REF_DIV);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pend;
    logic               w_last;
    logic               w_set;

    assign w_last = (r_cnt == c_cnt_w'(REF_DIV - 1));
    // Flag one tick ahead of the wrap so the refresh lands in the REF_DIV-th DMA slot.
    assign w_set  = tick && (r_cnt == c_cnt_w'(REF_DIV - 2));

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (tick) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_set) begin
                r_pend <= 1'b1;
            end else if (clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/dram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_slot_arbiter
// Purpose  : Alternating DMA/CPU RAM slot arbiter with refresh and acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module dram_slot_arbiter
    import dram_slot_arbiter_pkg::*;
#(
    parameter int REF_DIV = c_ref_div_default
) (
    input wire                 clk32,
    input wire                 porb,
    dram_slot_arbiter_if.slave bus
);

    phase_t r_phase;
    src_t   r_src;
    logic   r_ram_cyc;
    logic   r_refb;
    logic   r_vid_ack;
    logic   r_snd_ack;
    logic   r_dma_ack;
    logic   r_dtack_n;

    logic   w_pend;
    logic   w_dma_start;
    logic   w_ref_grant;
    src_t   w_next_src;

    // The slot about to start is a DMA slot when the current one is a CPU slot.
    assign w_dma_start = bus.slot_en && (r_phase == PH_CPU);
    assign w_ref_grant = bus.slot_en && (w_next_src == SRC_REF);

    always_comb begin
        w_next_src = SRC_IDLE;
        if (r_phase == PH_CPU) begin
            w_next_src = dma_grant(w_pend, bus.vid_req, bus.snd_req, bus.dma_req);
        end else if (bus.cpu_req && r_dtack_n) begin
            w_next_src = SRC_CPU;
        end
    end

    refresh_timer #(
        .REF_DIV (REF_DIV)
    ) u_refresh_timer (
        .clk32 (clk32),
        .porb  (porb),
        .tick  (w_dma_start),
        .clr   (w_ref_grant),
        .pend  (w_pend)
    );

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            r_phase   <= PH_CPU;
            r_src     <= SRC_IDLE;
            r_ram_cyc <= 1'b0;
            r_refb    <= 1'b1;
            r_vid_ack <= 1'b0;
            r_snd_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            r_dtack_n <= 1'b1;
        end else begin
            r_vid_ack <= 1'b0;
            r_snd_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            if (bus.slot_en) begin
                r_phase   <= (r_phase == PH_CPU) ? PH_DMA : PH_CPU;
                r_src     <= w_next_src;
                r_ram_cyc <= (w_next_src != SRC_IDLE);
                r_refb    <= (w_next_src != SRC_REF);
                r_vid_ack <= (r_src == SRC_VID);
                r_snd_ack <= (r_src == SRC_SND);
                r_dma_ack <= (r_src == SRC_DMA);
            end
            // A CPU that gave up before the slot ended gets no acknowledge.
            if (bus.slot_en && (r_src == SRC_CPU) && bus.cpu_req) begin
                r_dtack_n <= 1'b0;
            end else if (!bus.cpu_req) begin
                r_dtack_n <= 1'b1;
            end
        end
    end

    assign bus.src         = r_src;
    assign bus.ram_cyc     = r_ram_cyc;
    assign bus.refb        = r_refb;
    assign bus.vid_ack     = r_vid_ack;
    assign bus.snd_ack     = r_snd_ack;
    assign bus.dma_ack     = r_dma_ack;
    assign bus.cpu_dtack_n = r_dtack_n;

endmodule
`default_nettype wire

// File: tb/tb_dram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_slot_arbiter
// Purpose  : Directed scoreboard bench for dram_slot_arbiter with REF_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_slot_arbiter;

    typedef struct {
        logic [2:0] src;
        logic [2:0] ack;      // {vid, snd, dma} for the slot that just ended
        logic       dtack_n;
    } exp_t;

    logic clk32;
    logic porb;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];
    exp_t e;

    dram_slot_arbiter_if bus();

    dram_slot_arbiter #(
        .REF_DIV (4)
    ) dut (
        .clk32 (clk32),
        .porb  (porb),
        .bus   (bus)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every slot_en edge pops one expectation; other edges must show no ack.
    always @(posedge clk32) begin
        if (porb) begin
            if (bus.slot_en) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_slot: got slot with src %0d, expected none", bus.src);
                end else begin
                    e = exp_q.pop_front();
                    chk("slot_src", bus.src, e.src);
                    chk("slot_ram_cyc", bus.ram_cyc, e.src != 3'd0);
                    chk("slot_refb", bus.refb, e.src != 3'd5);
                    chk("slot_acks", {bus.vid_ack, bus.snd_ack, bus.dma_ack}, e.ack);
                    chk("slot_dtack_n", bus.cpu_dtack_n, e.dtack_n);
                end
            end else begin
                #1;
                chk("ack_idle", {bus.vid_ack, bus.snd_ack, bus.dma_ack}, 3'b000);
            end
        end
    end

    task automatic slot(input logic [2:0] s, input logic [2:0] a, input logic d, input int gap);
        exp_t x;
        x.src     = s;
        x.ack     = a;
        x.dtack_n = d;
        exp_q.push_back(x);
        bus.slot_en = 1'b1;
        @(negedge clk32);
        bus.slot_en = 1'b0;
        repeat (gap) @(negedge clk32);
    endtask

    task automatic do_reset();
        @(negedge clk32);
        porb        = 1'b0;
        bus.slot_en = 1'b0;
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        bus.snd_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clk32);
        porb = 1'b1;
        @(negedge clk32);
    endtask

    // Video held: DMA slot j shows 5 every 4th slot, else 2; CPU slots after a video slot ack it.
    task automatic vid_pattern(input int n);
        for (int k = 1; k <= n; k++) begin
            int j;
            j = (k + 1) / 2;
            if (k % 2 == 1)
                slot((j % 4 == 0) ? 3'd5 : 3'd2, 3'b000, 1'b1, k % 3);
            else
                slot(3'd0, (j % 4 != 0) ? 3'b100 : 3'b000, 1'b1, k % 3);
        end
    endtask

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        porb        = 1'b0;
        bus.slot_en = 1'b0;
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        bus.snd_req = 1'b0;
        bus.dma_req = 1'b0;
        repeat (2) @(negedge clk32);
        chk("rst_src", bus.src, 3'd0);
        chk("rst_ram_cyc", bus.ram_cyc, 1'b0);
        chk("rst_refb", bus.refb, 1'b1);
        chk("rst_acks", {bus.vid_ack, bus.snd_ack, bus.dma_ack}, 3'b000);
        chk("rst_dtack_n", bus.cpu_dtack_n, 1'b1);
        porb = 1'b1;
        @(negedge clk32);

        // Idle after reset
        for (int k = 0; k < 4; k++) slot(3'd0, 3'b000, 1'b1, 1);

        // Priority with all DMA requesters held, mixed spacing incl. back-to-back
        do_reset();
        bus.vid_req = 1'b1;
        bus.snd_req = 1'b1;
        bus.dma_req = 1'b1;
        vid_pattern(16);

        // CPU access, then release
        do_reset();
        slot(3'd0, 3'b000, 1'b1, 1);
        bus.cpu_req = 1'b1;
        slot(3'd1, 3'b000, 1'b1, 1);
        slot(3'd0, 3'b000, 1'b0, 1);
        slot(3'd0, 3'b000, 1'b0, 1);
        chk("dtack_held", bus.cpu_dtack_n, 1'b0);
        bus.cpu_req = 1'b0;
        @(posedge clk32);
        #1;
        chk("dtack_release", bus.cpu_dtack_n, 1'b1);
        @(negedge clk32);
        slot(3'd0, 3'b000, 1'b1, 1);
        slot(3'd0, 3'b000, 1'b1, 1);
        slot(3'd5, 3'b000, 1'b1, 1);
        slot(3'd0, 3'b000, 1'b1, 1);

        // CPU abandons its slot
        do_reset();
        slot(3'd0, 3'b000, 1'b1, 1);
        bus.cpu_req = 1'b1;
        slot(3'd1, 3'b000, 1'b1, 1);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk32);
        chk("abandon_src", bus.src, 3'd1);
        chk("abandon_dtack_n", bus.cpu_dtack_n, 1'b1);
        slot(3'd0, 3'b000, 1'b1, 2);
        slot(3'd0, 3'b000, 1'b1, 1);
        chk("abandon_dtack_after", bus.cpu_dtack_n, 1'b1);

        // Reset in the middle of a video slot
        do_reset();
        bus.vid_req = 1'b1;
        slot(3'd2, 3'b000, 1'b1, 1);
        slot(3'd0, 3'b100, 1'b1, 1);
        slot(3'd2, 3'b000, 1'b1, 1);
        porb = 1'b0;
        #1;
        chk("midrst_src", bus.src, 3'd0);
        chk("midrst_vid_ack", bus.vid_ack, 1'b0);
        chk("midrst_ram_cyc", bus.ram_cyc, 1'b0);
        chk("midrst_refb", bus.refb, 1'b1);
        @(negedge clk32);
        porb = 1'b1;
        @(negedge clk32);
        vid_pattern(8);

        repeat (3) @(negedge clk32);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_slot_arbiter.md
DRAM_SLOT_ARBITER -- requirements
Module: dram_slot_arbiter

Interface
REQ-001 SHALL have parameter REF_DIV, default 32, meaning the number of DMA slots between refresh requests (range 2..255).
REQ-002 SHALL have ports: clk32  in  1  system clock (single clock domain).
REQ-003 SHALL have: porb  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have: slot_en  in  1  one-clk32 pulse that ends the current slot and starts the next.
REQ-005 SHALL have: cpu_req  in  1  level, CPU RAM access pending (address strobe and RAM decode active).
REQ-006 SHALL have: vid_req, snd_req, dma_req  in  1 each  level requests for video fetch, sound DMA and disk DMA.
REQ-007 SHALL have: src  out  3  current slot owner: 0 idle, 1 cpu, 2 video, 3 sound, 4 disk DMA, 5 refresh.
REQ-008 SHALL have: ram_cyc  out  1  high while src is non-zero.
REQ-009 SHALL have: refb  out  1  low while src equals 5.
REQ-010 SHALL have: vid_ack, snd_ack, dma_ack  out  1 each  one-clk32 completion pulses.
REQ-011 SHALL have: cpu_dtack_n  out  1  active-low CPU acknowledge.

Function
REQ-012 SHALL keep a phase bit that toggles on every slot_en: phase 0 marks a DMA slot, phase 1 marks a CPU slot.
REQ-013 SHALL register src, ram_cyc and refb on the slot_en edge and hold them constant for the whole slot.
REQ-014 In a CPU slot, src SHALL be 1 if cpu_req is high and cpu_dtack_n is high at that slot_en; otherwise src SHALL be 0.
REQ-015 In a DMA slot, src SHALL follow fixed priority: refresh pending > vid_req > snd_req > dma_req > idle.
REQ-016 Each DMA slot SHALL advance a refresh counter that runs 0..REF_DIV-1 and wraps.
REQ-017 On counter wrap, a refresh-pending flag SHALL be set; wraps while the flag is already set SHALL NOT accumulate.
REQ-018 The refresh-pending flag SHALL clear at the slot_en that grants refresh; a set and a clear on the same edge SHALL leave the flag set.
REQ-019 At the slot_en ending a slot with src 2, 3 or 4, the matching ack SHALL pulse high for exactly one clk32 on the following cycle.
REQ-020 At the slot_en ending a CPU slot with src 1, cpu_dtack_n SHALL go low on the following cycle, but only if cpu_req is still high; otherwise it SHALL stay high.
REQ-021 cpu_dtack_n SHALL return high on the clk32 cycle after cpu_req is sampled low.
REQ-022 While cpu_dtack_n is low, no further CPU slot SHALL be granted, so one CPU bus cycle produces one RAM access.
REQ-023 A request dropped mid-slot SHALL NOT truncate the slot; the slot still ends on slot_en, and only the CPU ack is suppressed per REQ-020.
REQ-024 Requests SHALL have no effect between slot_en pulses other than the cpu_dtack_n release of REQ-021.
REQ-025 Back-to-back slot_en pulses on consecutive cycles SHALL be handled: each pulse is a complete slot.

Reset
REQ-026 When porb is low, all state SHALL clear asynchronously: src 0, ram_cyc 0, refb 1, all acks 0, cpu_dtack_n 1, refresh counter 0, refresh-pending 0.
REQ-027 Reset SHALL set phase to 1, so the first slot_en after reset starts a DMA slot.
REQ-028 Reset asserted mid-slot SHALL abort the slot with no ack emitted.

Structure
REQ-029 The src encodings (0..5) and the REF_DIV default SHALL live in the shared MCU constants include used by the address mux and the control logic.
REQ-030 The refresh counter and pending flag SHALL be a sub-module refresh_timer, with ports clk32, porb, tick (DMA slot start), clr (refresh grant) and pend.
REQ-031 The remaining logic (phase bit, priority encoder, ack and dtack generation) SHALL stay in dram_slot_arbiter.

Verification
REQ-032 Bench SHALL check reset release: with all requests low and 4 slot_en pulses, src = 0 throughout and refb = 1.
REQ-033 Bench SHALL check priority: with REF_DIV = 4 and vid_req = snd_req = dma_req = 1 held, the DMA slots show src 2,2,2,5,2,2,2,5; snd and dma are never granted, and vid_ack pulses once per video slot.
REQ-034 Bench SHALL check CPU access: cpu_req rises before the 2nd slot_en -> src = 1 during the CPU slot, and cpu_dtack_n is low one cycle after the next slot_en.
REQ-035 Bench SHALL check CPU release: cpu_dtack_n goes high one cycle after cpu_req drops, and the next CPU slot with cpu_req still low gives src = 0.
REQ-036 Bench SHALL check CPU abandon: cpu_req drops mid-CPU-slot -> src stays 1 until slot_en, and cpu_dtack_n never asserts.
REQ-037 Bench SHALL check reset mid-slot: porb pulled low during a video slot -> src = 0 and vid_ack = 0 immediately, and the refresh counter restarts from 0.
